pls_cnt_mod: RTL
================

# pls_cnt_mod

Parametrised modulo-N event counter for the watch time chain (seconds, minutes, hours, and later date fields). Counts falling edges of an asynchronous pulse input, and clears on a rising edge of an asynchronous clear input. Adds parallel load for time-setting, up/down direction, an enable gate and one-cycle wrap strobes. Its `plso` (half-period square) or `carry` output drives the next stage's `plsi`.

## Interface
- `MOD`, 60, counter modulus; legal range 2 ≤ MOD ≤ 2^W.
- `W`, 6, counter width in bits.
- `clk` input 1: single system clock; all logic on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `clr` input 1: asynchronous clear request; acts on its rising edge.
- `plsi` input 1: asynchronous count pulse; acts on its falling edge.
- `en` input 1: count enable; `clk`-domain level.
- `dn` input 1: direction, 0 = up, 1 = down; `clk`-domain level.
- `load` input 1: one-cycle `clk`-domain strobe; loads `load_val`.
- `load_val` input W: preset value.
- `qout` output reg W: current count, 0..MOD-1.
- `plso` output reg 1: 1 when qout ≥ MOD/2 (integer division), else 0.
- `carry` output reg 1: one-cycle pulse on up-wrap MOD-1→0.
- `brw` output reg 1: one-cycle pulse on down-wrap 0→MOD-1.
- `load_err` output reg 1: one-cycle pulse when `load` is rejected.

## Operation
- Synchronisers:
  - `clr` passes through two flops, c1 then c2. A clear event is c1 & ~c2.
  - `plsi` passes through two flops, p1 then p2. A pulse event is p2 & ~p1.
- Priority per cycle: rst > clear event > load > pulse event. Only the highest-priority action takes effect.
- Reset (`rst`=1 at an edge): c1, c2, p1, p2, qout, plso, carry, brw and load_err all go to 0.
- Clear event:
  - qout←0, plso←0, carry←0, brw←0.
  - p1 and p2 are forced to 0. A pulse event in the same cycle is discarded.
  - A `plsi` fall already sampled into p1 is also lost, because p2=0 afterwards.
- Load, when load_val < MOD: qout←load_val and plso←(load_val ≥ MOD/2). carry and brw stay 0.
- Load, when load_val ≥ MOD: qout is unchanged and load_err pulses for one cycle.
- A pulse event is counted only when en=1. With en=0 the event is dropped, not queued. The synchronisers keep running.
- Up count (dn=0):
  - qout < MOD-1: qout←qout+1.
  - qout = MOD-1: qout←0 and carry←1.
- Down count (dn=1):
  - qout > 0: qout←qout-1.
  - qout = 0: qout←MOD-1 and brw←1.
- plso is registered with qout, so plso == (qout ≥ MOD/2) holds in every cycle after reset.
- carry, brw and load_err are high for exactly one cycle per triggering event. Otherwise they are 0.
- Arithmetic is W bits wide. No intermediate value ever exceeds MOD-1.

## Timing
- Pulse latency:
  - Rising edge k samples plsi=0 after plsi=1, so p1←0 while p2 holds 1.
  - qout, plso, carry and brw update at edge k+1.
- Clear latency: edge k samples clr=1 after 0. qout is 0 from edge k+1.
- Load latency: load sampled high at edge k updates qout at edge k, with no synchroniser delay.
- Throughput:
  - One count per `plsi` low period.
  - plsi must be stable for at least 2 clk cycles high and 2 low.
  - Shorter glitches give undefined counts. There is no assertion, and this is not tested.
- rst is sampled only at clock edges. Asserting it mid-count fully restarts the block, including in-flight events.

## Test plan
- Reset, MOD=60/W=6: hold rst for 2 cycles, with plsi toggling and clr=1 → qout=0, plso=0, carry=brw=load_err=0. No count on release until a fresh plsi fall occurs.
- Up-count wrap, MOD=60: apply 60 plsi pulses (4 clk high / 4 low) with en=1, dn=0.
  - qout steps 1..59 then 0.
  - Each update lands exactly 2 edges after the plsi fall.
  - plso rises when qout=30 and falls at the wrap.
  - carry pulses once, in the wrap cycle.
- Down count and load, MOD=24/W=5:
  - load 5, then 6 pulses with dn=1 → 4,3,2,1,0,23. brw pulses once, and plso=1 at 23.
  - load 24 → qout stays 23 and load_err pulses once.
- Priority collision: align load=1 with a clr rising edge event and a pulse event in the same cycle → qout=0 (clear wins). The pulse is lost, the next pulse gives qout=1, and load is ignored.
- Enable gating: with qout=10, en=0, apply 3 pulses → qout stays 10. Set en=1 and apply 1 pulse → qout=11.
- Cascade: chain sec(60).plso→min(60).plsi and min.plso→hr(24).plsi. Starting from 23:59:59, one pulse → 00:00:00 after the ripple latency, with hr.carry pulsing once.

Source files
------------

// File: rtl/pls_cnt_mod.sv
// Modulo-MOD event counter for the watch time chain: counts synchronised plsi falls,
// clears on synchronised clr rises, with parallel load, up/down, enable and wrap strobes.
module pls_cnt_mod #(
   parameter int MOD = 60,
   parameter int W   = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         plsi,
   input  logic         en,
   input  logic         dn,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] qout,
   output logic         plso,
   output logic         carry,
   output logic         brw,
   output logic         load_err
);

   // Compares are done one bit wider so MOD = 2^W stays representable.
   localparam logic [W:0]   MOD_X  = (W+1)'(MOD);
   localparam logic [W:0]   HALF_X = (W+1)'(MOD / 2);
   localparam logic [W-1:0] MAX_V  = W'(MOD - 1);

   logic r_c1, r_c2, r_p1, r_p2;

   logic         w_clr_ev;
   logic         w_pls_ev;
   logic         w_load_ok;
   logic [W-1:0] w_q_nxt;
   logic         w_plso_nxt;
   logic         w_carry_nxt;
   logic         w_brw_nxt;
   logic         w_lerr_nxt;

   always_comb begin
      w_clr_ev    = r_c1 & ~r_c2;
      w_pls_ev    = r_p2 & ~r_p1 & en;
      w_load_ok   = ({1'b0, load_val} < MOD_X);
      w_q_nxt     = qout;
      w_carry_nxt = 1'b0;
      w_brw_nxt   = 1'b0;
      w_lerr_nxt  = 1'b0;
      if (w_clr_ev) begin
         w_q_nxt = '0;
      end else if (load) begin
         // A rejected load still outranks a pulse in the same cycle.
         if (w_load_ok) w_q_nxt    = load_val;
         else           w_lerr_nxt = 1'b1;
      end else if (w_pls_ev) begin
         if (!dn) begin
            if (qout == MAX_V) begin
               w_q_nxt     = '0;
               w_carry_nxt = 1'b1;
            end else begin
               w_q_nxt = qout + W'(1);
            end
         end else begin
            if (qout == '0) begin
               w_q_nxt   = MAX_V;
               w_brw_nxt = 1'b1;
            end else begin
               w_q_nxt = qout - W'(1);
            end
         end
      end
      w_plso_nxt = ({1'b0, w_q_nxt} >= HALF_X);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_c1     <= 1'b0;
         r_c2     <= 1'b0;
         r_p1     <= 1'b0;
         r_p2     <= 1'b0;
         qout     <= '0;
         plso     <= 1'b0;
         carry    <= 1'b0;
         brw      <= 1'b0;
         load_err <= 1'b0;
      end else begin
         r_c1 <= clr;
         r_c2 <= r_c1;
         // Clear flushes the pulse synchroniser so an in-flight fall is lost.
         if (w_clr_ev) begin
            r_p1 <= 1'b0;
            r_p2 <= 1'b0;
         end else begin
            r_p1 <= plsi;
            r_p2 <= r_p1;
         end
         qout     <= w_q_nxt;
         plso     <= w_plso_nxt;
         carry    <= w_carry_nxt;
         brw      <= w_brw_nxt;
         load_err <= w_lerr_nxt;
      end
   end

endmodule
